// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry registered buffer holding the instruction presented to decode.
module fetch_out_buf
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  consume,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [DATA_WIDTH-1:0] load_pc,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] pc
);

    // Clear wins over load so a redirect always flushes a same-cycle response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid <= 1'b0;
            data  <= DATA_WIDTH'(INSTR_NOP);
            pc    <= '0;
        end else begin
            if (clear) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end else if (consume) begin
                valid <= 1'b0;
            end
            if (load && !clear) begin
                data <= load_data;
                pc   <= load_pc;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives an external PC register and a single
// outstanding request to instruction memory, feeding decode through a buffer.
//
// state | meaning
// FETCH | may issue a request at pc_i; waits for grant
// WAIT  | request granted, waiting for rvalid (dropped if kill is set)
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  pc_en_o,
    output logic [DATA_WIDTH-1:0] pc_next_o,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o
);

    fetch_state_t          state_q, state_d;
    logic                  kill_q, kill_d;
    logic [DATA_WIDTH-1:0] req_pc_q;
    logic                  req, grant;
    logic                  buf_valid, buf_load, buf_consume;

    always_comb begin
        state_d  = state_q;
        kill_d   = kill_q;
        req      = 1'b0;
        grant    = 1'b0;
        buf_load = 1'b0;
        case (state_q)
            FETCH: begin
                req   = !redirect_i && (!buf_valid || !stall_i);
                grant = req && imem_gnt_i;
                if (grant) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A redirect while waiting marks the in-flight response stale.
                if (imem_rvalid_i) begin
                    state_d  = FETCH;
                    kill_d   = 1'b0;
                    buf_load = !kill_q && !redirect_i;
                end else if (redirect_i) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= FETCH;
            kill_q   <= 1'b0;
            req_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            if (grant) begin
                req_pc_q <= pc_i;
            end
        end
    end

    assign imem_req_o  = req && !rst_i;
    assign imem_addr_o = pc_i;
    assign pc_en_o     = !rst_i && (redirect_i || grant);
    assign pc_next_o   = redirect_i ? (redirect_pc_i & ~DATA_WIDTH'(3))
                                    : pc_i + DATA_WIDTH'(PC_INCR);

    assign buf_consume   = buf_valid && !stall_i;
    assign instr_valid_o = buf_valid;

    fetch_out_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (buf_load),
        .clear    (redirect_i),
        .consume  (buf_consume),
        .load_data(imem_rdata_i),
        .load_pc  (req_pc_q),
        .valid    (buf_valid),
        .data     (instr_o),
        .pc       (instr_pc_o)
    );

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, address/instruction width.
REQ-002 SHALL have parameter RESET_PC, default 0, value the external PC register holds after reset.
REQ-003 SHALL have port clk_i input 1 clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i input 1: asynchronous, active-high reset.
REQ-005 SHALL have port pc_i input DATA_WIDTH, current PC from external PC register.
REQ-006 SHALL have port pc_en_o output 1, load enable to PC register.
REQ-007 SHALL have port pc_next_o output DATA_WIDTH, next PC to PC register.
REQ-008 SHALL have port stall_i input 1, decode not accepting instruction this cycle.
REQ-009 SHALL have port redirect_i input 1, branch/jump taken; redirect_pc_i input DATA_WIDTH, target.
REQ-010 SHALL have ports imem_req_o output 1, imem_addr_o output DATA_WIDTH, imem_gnt_i input 1, request accepted.
REQ-011 SHALL have ports imem_rvalid_i input 1, imem_rdata_i input DATA_WIDTH, response; at most one outstanding request.
REQ-012 SHALL have ports instr_valid_o output 1, instr_o output DATA_WIDTH, instr_pc_o output DATA_WIDTH, registered instruction to decode.

Function
REQ-013 SHALL implement FSM states FETCH and WAIT, plus kill flag and one-entry output buffer (out_valid).
REQ-014 Output transfer SHALL occur on a cycle with instr_valid_o=1 and stall_i=0; buffer then clears unless reloaded.
REQ-015 FETCH: imem_req_o=1, imem_addr_o=pc_i, when !redirect_i and (!out_valid or !stall_i); otherwise imem_req_o=0.
REQ-016 FETCH with req and gnt: go WAIT, latch req_pc=pc_i, pc_en_o=1, pc_next_o=pc_i+4 (modulo 2^DATA_WIDTH, wraps 0xFFFFFFFC->0).
REQ-017 FETCH with req and no gnt: hold imem_addr_o stable, pc_en_o=0, stay FETCH.
REQ-018 WAIT: imem_req_o=0; on imem_rvalid_i with kill=0 load buffer (instr_o=imem_rdata_i, instr_pc_o=req_pc, out_valid=1) and go FETCH.
REQ-019 WAIT: on imem_rvalid_i with kill=1 discard data, clear kill, go FETCH, buffer unchanged.
REQ-020 redirect_i SHALL have highest priority: pc_en_o=1, pc_next_o={redirect_pc_i[DW-1:2],2'b00}, out_valid cleared same edge, imem_req_o=0 that cycle.
REQ-021 redirect_i in WAIT without rvalid: set kill=1, stay WAIT; with rvalid same cycle: drop response, go FETCH, kill=0.
REQ-022 redirect_i SHALL override stall_i; stall_i SHALL NOT affect an already-granted request.
REQ-023 pc_en_o=0 in all cases not covered by REQ-016/REQ-020.
REQ-024 Latency: gnt at cycle N, rvalid at N+k (k>=1) -> instr_valid_o=1 at N+k+1.
REQ-025 imem_rvalid_i in FETCH SHALL be ignored (protocol error; no state change).

Reset
REQ-026 While rst_i=1: state=FETCH, kill=0, out_valid=0, req_pc=RESET_PC, instr_valid_o=0, instr_o=NOP (0x00000013), instr_pc_o=0.
REQ-027 While rst_i=1: imem_req_o=0, pc_en_o=0; first request at first edge after deassertion, address pc_i (=RESET_PC).
REQ-028 Reset mid-WAIT SHALL abandon the outstanding request; a late rvalid after reset SHALL be ignored per REQ-025.

Structure
REQ-029 Package fetch_pkg SHALL hold fetch_state_t enum (FETCH, WAIT), INSTR_NOP constant, PC_INCR=4.
REQ-030 Output buffer SHALL be sub-module fetch_out_buf (load, clear, consume; registered data, pc, valid).
REQ-031 fetch_ctrl SHALL NOT contain the PC register; it drives the external one via pc_en_o/pc_next_o.

Verification
REQ-032 Reset, gnt=1, rvalid one cycle later, stall=0 -> addresses 0x0,0x4,0x8 issued; instr_pc_o 0x0,0x4,0x8 in order.
REQ-033 gnt low 3 cycles at pc 0x10 -> imem_addr_o stays 0x10, pc_en_o=0 for 3 cycles, then PC 0x14.
REQ-034 Buffer full, stall_i=1 for 4 cycles -> imem_req_o=0, instr_o/instr_pc_o stable; resumes on stall_i=0.
REQ-035 redirect_i to 0x103 while WAIT for 0x20 -> response for 0x20 discarded, next request 0x100, instr_pc_o never 0x20.
REQ-036 redirect_i same cycle as rvalid, and redirect with stall_i=1 -> response dropped, buffer cleared, next address = target.
REQ-037 pc_i=0xFFFFFFFC granted -> pc_next_o=0x0; rst_i asserted mid-WAIT -> all outputs to REQ-026 values immediately.
